kf_run_scheduler: RTL and testbench
===================================

# kf_run_scheduler

Run scheduler for the Kalman-filter microcode sequencer. It accepts one measurement per filter iteration over a valid/ready handshake and latches it for the datapath. It launches one sequencer program run per measurement with a one-cycle `seq_start`, then tracks the run through the sequencer's READY handshake. It publishes a completion over valid/ready, counts iterations against a limit, and traps hung runs with a watchdog.

## Interface
- `ITER_W`, 16: width of the iteration counter and the iteration limit.
- `TO_W`, 12: width of the watchdog timer and the timeout threshold.
- `DATA_W`, 16: measurement width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: permits acceptance of new measurements.
- `meas_valid` in 1: measurement offered.
- `meas_data` in DATA_W: measurement value.
- `meas_ready` out 1: scheduler can accept a measurement.
- `meas_q` out DATA_W: latched measurement, held stable for the datapath.
- `seq_start` out 1: registered one-cycle start pulse to the sequencer.
- `seq_ready` in 1: sequencer READY (1 = idle).
- `out_valid` out 1: iteration complete.
- `out_ready` in 1: downstream accepts the completion.
- `iter_limit` in ITER_W: maximum number of iterations; 0 = unlimited.
- `cnt_clr` in 1: synchronous clear of `iter_count`.
- `timeout_cycles` in TO_W: watchdog threshold; 0 disables the watchdog.
- `clr_err` in 1: exits the ERR state.
- `iter_count` out ITER_W: completed iterations.
- `busy` out 1: state is neither IDLE nor ERR.
- `timeout_err` out 1: sticky flag, high while in ERR.
- `state_dbg` out 3: current state encoding.

## Operation
States and encodings: IDLE=0, LAUNCH=1, WAIT_ACK=2, RUN=3, DONE=4, ERR=5. Encodings 6–7 return to IDLE on the next edge.

- **IDLE**
  - `meas_ready` = `enable` & !(`iter_limit`!=0 & `iter_count`>=`iter_limit`). This is combinational from registered state and inputs.
  - On `meas_valid` & `meas_ready`: `meas_q` <= `meas_data`, go to LAUNCH.
- **LAUNCH**
  - If `seq_ready`=1: `seq_start` <= 1, timer <= 0, go to WAIT_ACK.
  - Otherwise hold. The timer does not run in LAUNCH.
- **WAIT_ACK**
  - `seq_start` <= 0.
  - Timer increments.
  - Go to RUN on the first sampled `seq_ready`=0.
  - `seq_ready`=1 during the `seq_start` cycle is expected and ignored.
- **RUN**
  - Timer increments.
  - On `seq_ready`=1: `iter_count` += 1 (wraps modulo 2^ITER_W), go to DONE.
- **DONE**
  - `out_valid`=1.
  - On `out_ready`: go to IDLE.
- **ERR**
  - `timeout_err`=1, `meas_ready`=0.
  - On `clr_err`: go to IDLE.
  - `clr_err` in any other state is ignored.
- **Watchdog** (applies in WAIT_ACK and RUN, when `timeout_cycles`!=0)
  - At an edge where timer == `timeout_cycles` and completion (`seq_ready`=1 in RUN) is not also occurring, go to ERR.
  - If completion and timeout coincide, completion wins.
  - The timer saturates at all-ones.
- **Counter clear**
  - `cnt_clr` zeroes `iter_count` in any state.
  - When `cnt_clr` coincides with an increment, the clear wins.
- **`enable` deassertion**
  - Affects only IDLE acceptance.
  - A run in progress always completes.
- **`meas_q`** changes only on an accepted measurement.

## Timing
- **Reset values:** state IDLE; `seq_start`=0, `out_valid`=0, `busy`=0, `timeout_err`=0, `iter_count`=0, `meas_q`=0, timer=0, `state_dbg`=0. `meas_ready` follows its IDLE equation immediately after reset.
- **Reset mid-run:** abandons the run at once and drives no `seq_start`. The sequencer is reset separately.
- **Launch sequence:**
  - Accept at edge E0 -> LAUNCH.
  - E1 (`seq_ready`=1) -> `seq_start` high for the cycle E1..E2.
  - Sequencer drops READY at E2.
  - Scheduler samples it at E3 -> RUN.
- **Completion:** sequencer raises READY at edge Er -> scheduler enters DONE at Er+1 with `out_valid`=1 and the updated `iter_count` visible.
- **Back-to-back:** the completion handshake at edge Ed -> IDLE; `meas_ready` is high in the cycle after Ed. There is no combinational `out_ready`->`meas_ready` path.
- **`seq_start` width:** always exactly one cycle, at most once per accepted measurement.

## Test plan
- **Basic run:** `enable`=1, sequencer model drops READY 1 cycle after start and raises it 10 cycles later; offer `meas_data`=0x1234 -> `meas_q`=0x1234, single `seq_start` pulse, `out_valid` at Er+1, `iter_count`=1, `meas_ready` high after `out_ready`.
- **Busy sequencer:** hold `seq_ready`=0 for 5 cycles after accept -> stays in LAUNCH (`state_dbg`=1), no `seq_start`, timer idle; start issues the cycle after READY rises.
- **Watchdog:** `timeout_cycles`=8, sequencer never raises READY -> ERR (`state_dbg`=5), `timeout_err`=1, `meas_ready`=0; pulse `clr_err` -> IDLE, `timeout_err`=0. Repeat with READY rising exactly at the timeout edge -> DONE, no error.
- **Iteration limit:** `iter_limit`=3, run 3 iterations -> `meas_ready`=0 with `meas_valid` held high. `cnt_clr` coincident with the 3rd increment -> `iter_count`=0 and acceptance resumes.
- **Downstream stall and enable:** hold `out_ready`=0 for 20 cycles -> `out_valid` stays high, no new accept. Drop `enable` mid-RUN -> run completes and no further measurement is taken.
- **Async reset:** assert `rst_n`=0 mid-RUN between clock edges -> all outputs reach their reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/kf_run_scheduler.sv
// kf_run_scheduler: accepts one measurement per filter iteration, launches one
// sequencer run per measurement, tracks it through the sequencer READY
// handshake, publishes completion, counts iterations and traps hung runs.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable                permits acceptance of new measurements
//   meas_valid/ready/data measurement handshake; meas_q holds the accepted value
//   seq_start, seq_ready  one-cycle start pulse out, sequencer READY (1=idle) in
//   out_valid, out_ready  iteration completion handshake
//   iter_limit, cnt_clr   iteration limit (0=unlimited), sync clear of iter_count
//   timeout_cycles        watchdog threshold (0=disabled)
//   clr_err               leaves the ERR state
//   iter_count, busy, timeout_err, state_dbg   status outputs
module kf_run_scheduler #(
    parameter int ITER_W = 16,
    parameter int TO_W   = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              meas_valid,
    input  logic [DATA_W-1:0] meas_data,
    output logic              meas_ready,
    output logic [DATA_W-1:0] meas_q,
    output logic              seq_start,
    input  logic              seq_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [ITER_W-1:0] iter_limit,
    input  logic              cnt_clr,
    input  logic [TO_W-1:0]   timeout_cycles,
    input  logic              clr_err,
    output logic [ITER_W-1:0] iter_count,
    output logic              busy,
    output logic              timeout_err,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_ACK = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4,
        ERR      = 3'd5
    } state_t;

    localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]   TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic [TO_W-1:0] timer;
    logic            at_limit;
    logic            wd_hit;
    logic            done_now;
    logic            timing;

    assign at_limit   = (iter_limit != '0) && (iter_count >= iter_limit);
    assign meas_ready = (state == IDLE) && enable && !at_limit;

    assign timing   = (state == WAIT_ACK) || (state == RUN);
    assign wd_hit   = (timeout_cycles != '0) && (timer == timeout_cycles);
    assign done_now = (state == RUN) && seq_ready;

    // Status outputs are pure decodes of the state register.
    assign out_valid   = (state == DONE);
    assign timeout_err = (state == ERR);
    assign busy        = (state != IDLE) && (state != ERR);
    assign state_dbg   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            seq_start  <= 1'b0;
            meas_q     <= '0;
            iter_count <= '0;
        end else begin
            seq_start <= 1'b0;

            // Watchdog timer saturates so a long hang never wraps past the threshold.
            if (timing && (timer != '1)) begin
                timer <= timer + TO_ONE;
            end

            case (state)
                IDLE: begin
                    if (meas_valid && meas_ready) begin
                        meas_q <= meas_data;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (seq_ready) begin
                        seq_start <= 1'b1;
                        timer     <= '0;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // READY still high during the start cycle is normal; wait for it to drop.
                    if (wd_hit) begin
                        state <= ERR;
                    end else if (!seq_ready) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Completion beats a coincident timeout.
                    if (seq_ready) begin
                        state <= DONE;
                    end else if (wd_hit) begin
                        state <= ERR;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                ERR: begin
                    if (clr_err) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (cnt_clr) begin
                iter_count <= '0;
            end else if (done_now) begin
                iter_count <= iter_count + ITER_ONE;
            end
        end
    end

endmodule

// File: tb/tb_kf_run_scheduler.sv
// tb_kf_run_scheduler: self-checking bench for kf_run_scheduler.
// Transaction-level reference: run outcome predicted from latencies and threshold.
module tb_kf_run_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        meas_valid = 1'b0;
    logic [15:0] meas_data = '0;
    logic        meas_ready;
    logic [15:0] meas_q;
    logic        seq_start;
    logic        seq_ready = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] iter_limit = '0;
    logic        cnt_clr = 1'b0;
    logic [11:0] timeout_cycles = '0;
    logic        clr_err = 1'b0;
    logic [15:0] iter_count;
    logic        busy;
    logic        timeout_err;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    kf_run_scheduler #(.ITER_W(16), .TO_W(12), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .meas_valid(meas_valid), .meas_data(meas_data),
        .meas_ready(meas_ready), .meas_q(meas_q),
        .seq_start(seq_start), .seq_ready(seq_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .iter_limit(iter_limit), .cnt_clr(cnt_clr),
        .timeout_cycles(timeout_cycles), .clr_err(clr_err),
        .iter_count(iter_count), .busy(busy),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          b;
        int          r;
        int          t;
        int          dly;
        bit          err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_ready();
        return enable && !(iter_limit != 0 && exp_cnt >= int'(iter_limit));
    endfunction

    // One measurement: sequencer busy for b cycles in LAUNCH, drops READY
    // one edge after the start pulse, raises it r cycles later.
    // mode 1: cnt_clr on the completion edge; mode 2: drop enable mid-run.
    task automatic do_txn(input logic [15:0] d, input int b, input int r,
                          input int t, input int dly, input bit exp_err,
                          input int mode);
        bit st_bad;
        int endj;
        timeout_cycles = t[11:0];
        seq_ready = (b == 0);
        out_ready = 1'b0;
        meas_data = d;
        meas_valid = 1'b1;
        chk("ready_pre", meas_ready, 1);
        tick();
        meas_valid = 1'b0;
        meas_data = ~d;
        chk("meas_q", meas_q, d);
        chk("launch_state", state_dbg, 1);
        st_bad = 0;
        for (int i = 0; i < b; i++) begin
            if (seq_start || state_dbg != 3'd1) st_bad = 1;
            tick();
        end
        seq_ready = 1'b1;
        if (seq_start || state_dbg != 3'd1) st_bad = 1;
        chk("launch_hold", st_bad, 0);
        tick();
        chk("start_hi", seq_start, 1);
        chk("wait_ack", state_dbg, 2);
        tick();
        chk("start_lo", seq_start, 0);
        seq_ready = 1'b0;
        endj = exp_err ? t : r + 1;
        st_bad = 0;
        for (int j = 1; j <= endj; j++) begin
            if (mode == 2 && j == 1) enable = 1'b0;
            tick();
            if (j < endj) begin
                if (state_dbg != 3'd3 || seq_start || out_valid ||
                    !busy || meas_q != d) st_bad = 1;
            end
            if (j == r) begin
                seq_ready = 1'b1;
                if (mode == 1) cnt_clr = 1'b1;
            end
        end
        cnt_clr = 1'b0;
        chk("run_phase", st_bad, 0);
        if (exp_err) begin
            seq_ready = 1'b1;
            meas_valid = 1'b1;
            chk("err_state", state_dbg, 5);
            chk("err_flag", timeout_err, 1);
            chk("err_mready", meas_ready, 0);
            chk("err_busy", busy, 0);
            chk("err_cnt", iter_count, exp_cnt[15:0]);
            tick();
            tick();
            chk("err_sticky", state_dbg, 5);
            clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
            meas_valid = 1'b0;
            chk("err_clr", state_dbg, 0);
            chk("err_flag_clr", timeout_err, 0);
        end else begin
            exp_cnt = (mode == 1) ? 0 : (exp_cnt + 1) % 65536;
            chk("done_state", state_dbg, 4);
            chk("out_valid", out_valid, 1);
            chk("iter_count", iter_count, exp_cnt[15:0]);
            meas_valid = 1'b1;
            meas_data = d ^ 16'h5555;
            st_bad = 0;
            for (int i = 0; i < dly; i++) begin
                tick();
                if (!out_valid || meas_ready || meas_q != d) st_bad = 1;
            end
            chk("stall", st_bad, 0);
            meas_valid = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("idle_after", state_dbg, 0);
            chk("ready_after", meas_ready, exp_ready());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h1234, 0, 10, 0,    0,  1'b0};
        tbl[1] = '{16'hA5A5, 5, 3,  0,    2,  1'b0};
        tbl[2] = '{16'h0001, 0, 50, 8,    0,  1'b1};
        tbl[3] = '{16'h0002, 0, 7,  8,    0,  1'b0};
        tbl[4] = '{16'h0003, 0, 8,  8,    0,  1'b1};
        tbl[5] = '{16'hFFFF, 2, 1,  1,    0,  1'b1};
        tbl[6] = '{16'h8000, 0, 1,  2,    1,  1'b0};
        tbl[7] = '{16'h0F0F, 3, 4,  4095, 20, 1'b0};

        #3;
        chk("rst_state", state_dbg, 0);
        chk("rst_start", seq_start, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_cnt", iter_count, 0);
        chk("rst_measq", meas_q, 0);
        chk("rst_mready", meas_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) begin
            do_txn(tbl[k].d, tbl[k].b, tbl[k].r, tbl[k].t, tbl[k].dly,
                   tbl[k].err, 0);
        end

        for (int k = 0; k < 40; k++) begin
            logic [15:0] d;
            int b, r, t, dly;
            d = 16'($urandom);
            b = $urandom_range(0, 3);
            r = $urandom_range(1, 12);
            t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 14);
            dly = $urandom_range(0, 3);
            do_txn(d, b, r, t, dly, (t != 0) && (r + 1 > t), 0);
        end

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_cnt = 0;
        chk("cnt_clr", iter_count, 0);
        iter_limit = 16'd3;
        for (int k = 0; k < 3; k++) do_txn(16'h0100 + 16'(k), 0, 2, 0, 0, 0, 0);
        meas_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("limit_state", state_dbg, 0);
        chk("limit_mready", meas_ready, 0);
        chk("limit_measq", meas_q, 16'h0102);
        meas_valid = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_cnt = 0;
        do_txn(16'h0200, 0, 2, 0, 0, 0, 0);
        do_txn(16'h0201, 0, 2, 0, 0, 0, 0);
        do_txn(16'h0202, 0, 3, 0, 0, 0, 1);
        chk("clr_resume", meas_ready, 1);
        iter_limit = '0;

        do_txn(16'hBEEF, 0, 4, 0, 1, 0, 2);
        meas_valid = 1'b1;
        meas_data = 16'h1111;
        for (int i = 0; i < 5; i++) tick();
        chk("en_state", state_dbg, 0);
        chk("en_measq", meas_q, 16'hBEEF);
        chk("en_start", seq_start, 0);
        meas_valid = 1'b0;
        enable = 1'b1;

        timeout_cycles = '0;
        seq_ready = 1'b1;
        meas_data = 16'h5A5A;
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        tick();
        tick();
        seq_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_run", state_dbg, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state_dbg, 0);
        chk("arst_start", seq_start, 0);
        chk("arst_ovalid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_terr", timeout_err, 0);
        chk("arst_cnt", iter_count, 0);
        chk("arst_measq", meas_q, 0);
        chk("arst_mready", meas_ready, 1);
        exp_cnt = 0;
        seq_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        tick();
        do_txn(16'h7777, 1, 5, 6, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
